// File: rtl/priority_encoder.sv
// rtl/priority_encoder.sv - registered highest-index-first priority encoder (optional PRI_ENC_ONEHOT_EN adds one-hot grant output)
module priority_encoder #(
    parameter  int IN_W  = 8,
    localparam int OUT_W = $clog2(IN_W)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [IN_W-1:0]  in,
    input  logic             valid,
`ifdef PRI_ENC_ONEHOT_EN
    output logic [IN_W-1:0]  grant,
`endif
    output logic [OUT_W-1:0] out,
    output logic             found
);

    logic [OUT_W-1:0] next_out;
    logic             next_found;
`ifdef PRI_ENC_ONEHOT_EN
    logic [IN_W-1:0]  next_grant;
`endif

    // Search from bit 0 upward so the last set bit seen, the highest index, wins;
    // when valid is low the vector is never examined, so X/Z on it cannot leak out.
    always_comb begin
        next_out   = '0;
        next_found = 1'b0;
`ifdef PRI_ENC_ONEHOT_EN
        next_grant = '0;
`endif
        if (valid) begin
            for (int i = 0; i < IN_W; i++) begin
                if (in[i]) begin
                    next_out   = OUT_W'(i);
                    next_found = 1'b1;
`ifdef PRI_ENC_ONEHOT_EN
                    next_grant    = '0;
                    next_grant[i] = 1'b1;
`endif
                end
            end
        end
    end

    // Capture the encoded result each cycle; reset clears outputs without waiting for clk.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out   <= '0;
            found <= 1'b0;
`ifdef PRI_ENC_ONEHOT_EN
            grant <= '0;
`endif
        end else begin
            out   <= next_out;
            found <= next_found;
`ifdef PRI_ENC_ONEHOT_EN
            grant <= next_grant;
`endif
        end
    end

endmodule

// File: tb/tb_priority_encoder.sv
// tb/tb_priority_encoder.sv - directed self-checking bench for priority_encoder
module tb_priority_encoder;

    logic       clk;
    logic       rst_n;
    logic [7:0] in;
    logic       valid;
    logic [2:0] out;
    logic       found;
`ifdef PRI_ENC_ONEHOT_EN
    logic [7:0] grant;
`endif

    int errors;
    int checks;

    priority_encoder #(.IN_W(8)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .in    (in),
        .valid (valid),
`ifdef PRI_ENC_ONEHOT_EN
        .grant (grant),
`endif
        .out   (out),
        .found (found)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one rising edge and settle away from it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        valid = 1'b1;
        in    = 8'hFF;
        #2;
        for (int c = 0; c < 3; c++) begin
            tick();
            checks++;
            if (out !== 3'b000 || found !== 1'b0) begin
                errors++;
                $display("FAIL reset_hold cycle %0d: out=%b found=%b expected out=000 found=0", c, out, found);
            end
        end
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        checks++;
        if (out !== 3'b000 || found !== 1'b0) begin
            errors++;
            $display("FAIL reset_release_hold: out=%b found=%b expected out=000 found=0", out, found);
        end
        tick();
        checks++;
        if (out !== 3'b111 || found !== 1'b1) begin
            errors++;
            $display("FAIL first_edge_after_reset: out=%b found=%b expected out=111 found=1", out, found);
        end
    endtask

    task automatic test_async_reset();
        valid = 1'b1;
        in    = 8'h80;
        tick();
        checks++;
        if (out !== 3'b111 || found !== 1'b1) begin
            errors++;
            $display("FAIL async_pre: out=%b found=%b expected out=111 found=1", out, found);
        end
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (out !== 3'b000 || found !== 1'b0) begin
            errors++;
            $display("FAIL async_reset_immediate: out=%b found=%b expected out=000 found=0", out, found);
        end
        @(negedge clk);
        rst_n = 1'b1;
        #1;
    endtask

    task automatic test_gating();
        valid = 1'b0;
        in    = 8'h66;
        tick();
        checks++;
        if (out !== 3'b000 || found !== 1'b0) begin
            errors++;
            $display("FAIL gating_valid0: out=%b found=%b expected out=000 found=0", out, found);
        end
        valid = 1'b1;
        in    = 8'h43;
        tick();
        checks++;
        if (out !== 3'b110 || found !== 1'b1) begin
            errors++;
            $display("FAIL gating_valid1: out=%b found=%b expected out=110 found=1", out, found);
        end
        valid = 1'b0;
        in    = 8'bxxxxzzzz;
        tick();
        checks++;
        if (out !== 3'b000 || found !== 1'b0) begin
            errors++;
            $display("FAIL gating_xz: out=%b found=%b expected out=000 found=0", out, found);
        end
    endtask

    task automatic test_priority();
        logic [7:0] vec [6];
        logic [2:0] exp [6];
        vec = '{8'h15, 8'h75, 8'h05, 8'h56, 8'h80, 8'h01};
        exp = '{3'b100, 3'b110, 3'b010, 3'b110, 3'b111, 3'b000};
        valid = 1'b1;
        for (int k = 0; k < 6; k++) begin
            in = vec[k];
            tick();
            checks++;
            if (out !== exp[k] || found !== 1'b1) begin
                errors++;
                $display("FAIL priority in=%h: out=%b found=%b expected out=%b found=1", vec[k], out, found, exp[k]);
            end
        end
    endtask

    task automatic test_back_to_back();
        valid = 1'b1;
        in    = 8'h00;
        tick();
        checks++;
        if (out !== 3'b000 || found !== 1'b0) begin
            errors++;
            $display("FAIL zero_input: out=%b found=%b expected out=000 found=0", out, found);
        end
        in = 8'h01;
        tick();
        checks++;
        if (out !== 3'b000 || found !== 1'b1) begin
            errors++;
            $display("FAIL b2b_one: out=%b found=%b expected out=000 found=1", out, found);
        end
        in = 8'h00;
        tick();
        checks++;
        if (out !== 3'b000 || found !== 1'b0) begin
            errors++;
            $display("FAIL b2b_zero: out=%b found=%b expected out=000 found=0", out, found);
        end
    endtask

    task automatic test_exhaustive();
        logic [7:0] v;
        logic [2:0] ref_idx;
        logic       ref_found;
        valid = 1'b1;
        for (int n = 0; n < 256; n++) begin
            in        = n[7:0];
            v         = n[7:0];
            ref_idx   = 3'd0;
            ref_found = (v != 8'h00);
            while (v > 8'h01) begin
                v = v >> 1;
                ref_idx = ref_idx + 3'd1;
            end
            tick();
            checks++;
            if (out !== ref_idx || found !== ref_found) begin
                errors++;
                $display("FAIL exhaustive in=%h: out=%b found=%b expected out=%b found=%b", n[7:0], out, found, ref_idx, ref_found);
            end
        end
    endtask

`ifdef PRI_ENC_ONEHOT_EN
    task automatic test_onehot();
        valid = 1'b1;
        in    = 8'h56;
        tick();
        checks++;
        if (grant !== 8'h40) begin
            errors++;
            $display("FAIL grant_56: grant=%h expected 40", grant);
        end
        in = 8'h00;
        tick();
        checks++;
        if (grant !== 8'h00) begin
            errors++;
            $display("FAIL grant_00: grant=%h expected 00", grant);
        end
        in = 8'h81;
        tick();
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (grant !== 8'h00) begin
            errors++;
            $display("FAIL grant_async_reset: grant=%h expected 00", grant);
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask
`endif

    initial begin
        errors = 0;
        checks = 0;
        rst_n  = 1'b0;
        valid  = 1'b0;
        in     = 8'h00;
        test_reset();
        test_async_reset();
        test_gating();
        test_priority();
        test_back_to_back();
        test_exhaustive();
`ifdef PRI_ENC_ONEHOT_EN
        test_onehot();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
